// File: rtl/bf16_fp8_pack_ctrl.sv
// Streaming BF16 -> FP8 (E4M3 with Inf/NaN encodings) quantiser that packs LANES
// results per output word and keeps sticky conversion-exception flags.

module bf16_to_fp8 (
  input  logic [15:0] bf16_i,
  output logic [7:0]  fp8_o,
  output logic        nan_o,
  output logic        sat_o,
  output logic        unf_o
);
  logic [7:0]  e, ediff, sh, sum;
  logic [6:0]  m, mag;
  logic [15:0] ext;
  logic        rnd;

  always_comb begin
    e     = bf16_i[14:7];
    m     = bf16_i[6:0];
    ediff = e - 8'd120;
    sh    = 8'd125 - e;
    ext   = 16'h0;
    sum   = 8'h0;
    rnd   = 1'b0;
    mag   = 7'h0;
    if (e == 8'hFF) begin
      mag = (m != 7'h0) ? 7'h79 : 7'h78;
    end else if (e == 8'h0) begin
      mag = 7'h0;
    end else if (e >= 8'd135) begin
      mag = 7'h78;
    end else if (e >= 8'd121) begin
      // normal range: keep 3 mantissa bits, round to nearest even
      rnd = m[3] & ((|m[2:0]) | m[4]);
      sum = {1'b0, ediff[3:0], m[6:4]} + {7'h0, rnd};
      mag = (sum >= 8'h78) ? 7'h78 : sum[6:0];
    end else begin
      // subnormal range; a round-up into 8 lands exactly on the smallest normal
      if (sh <= 8'd15) ext = {1'b1, m, 8'h0} >> sh[3:0];
      rnd = ext[7] & ((|ext[6:0]) | ext[8]);
      sum = ext[15:8] + {7'h0, rnd};
      mag = sum[6:0];
    end
    fp8_o = {bf16_i[15], mag};
    nan_o = (e == 8'hFF) && (m != 7'h0);
    sat_o = (e != 8'hFF) && (mag == 7'h78);
    unf_o = (bf16_i[14:0] != 15'h0) && (mag == 7'h0);
  end
endmodule

module bf16_fp8_pack_ctrl #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_data,
  input  logic               in_last,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [LANES-1:0]   out_keep,
  output logic               out_last,
  input  logic               clear_flags,
  output logic               sat_flag,
  output logic               nan_flag,
  output logic               unf_flag
);
  localparam int CW = $clog2(LANES);

  typedef enum logic [1:0] {EMPTY, FILL, FILL_PEND} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [8*LANES-1:0] acc_q, acc_d, word, data_q, data_d;
  logic [LANES-1:0]   keep_q, keep_d, keep_w;
  logic               last_q, last_d, ov_q, ov_d, pend_q, pend_d;
  logic               sat_q, sat_d, nan_q, nan_d, unf_q, unf_d;
  logic [7:0]         fp8;
  logic               ev_nan, ev_sat, ev_unf;
  logic               accept, close, has_data;
  logic [CW:0]        filled;

  bf16_to_fp8 u_cvt (
    .bf16_i (in_data),
    .fp8_o  (fp8),
    .nan_o  (ev_nan),
    .sat_o  (ev_sat),
    .unf_o  (ev_unf)
  );

  assign in_ready = !(ov_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign has_data = (state_q != EMPTY);

  always_comb begin
    word   = acc_q;
    keep_w = '0;
    filled = {1'b0, cnt_q} + {{CW{1'b0}}, accept};
    for (int k = 0; k < LANES; k++) begin
      if (accept && cnt_q == CW'(k)) word[8*k +: 8] = fp8;
      keep_w[k] = ((CW+1)'(k) < filled);
    end
    // a pending flush fires on the first cycle the output path is free
    if (accept)
      close = (cnt_q == CW'(LANES-1)) || in_last || flush || pend_q;
    else
      close = in_ready && (flush || pend_q) && has_data;

    acc_d  = close ? '0 : word;
    cnt_d  = close ? '0 : (accept ? cnt_q + CW'(1) : cnt_q);
    pend_d = in_ready ? 1'b0 : (pend_q || flush);

    state_d = state_q;
    if (close)                          state_d = EMPTY;
    else if (accept || state_q != EMPTY) state_d = pend_d ? FILL_PEND : FILL;

    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    ov_d   = ov_q;
    if (close) begin
      data_d = word;
      keep_d = keep_w;
      last_d = accept && in_last;
      ov_d   = 1'b1;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end

    sat_d = (sat_q && !clear_flags) || (accept && ev_sat);
    nan_d = (nan_q && !clear_flags) || (accept && ev_nan);
    unf_d = (unf_q && !clear_flags) || (accept && ev_unf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      acc_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
      sat_q   <= 1'b0;
      nan_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      ov_q    <= ov_d;
      sat_q   <= sat_d;
      nan_q   <= nan_d;
      unf_q   <= unf_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;
  assign sat_flag  = sat_q;
  assign nan_flag  = nan_q;
  assign unf_flag  = unf_q;
endmodule

// File: tb/tb_bf16_fp8_pack_ctrl.sv
// Directed bench for bf16_fp8_pack_ctrl (LANES=4): packing, stalls, flush, flags, reset.

module tb_bf16_fp8_pack_ctrl;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_last, flush;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_last, clear_flags;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        sat_flag, nan_flag, unf_flag;
  int          checks = 0;
  int          failures = 0;

  bf16_fp8_pack_ctrl #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .clear_flags(clear_flags),
    .sat_flag(sat_flag), .nan_flag(nan_flag), .unf_flag(unf_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l, input logic f);
    in_valid = 1'b1; in_data = d; in_last = l; flush = f;
    step();
    in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                          input logic l);
    chk({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
    chk({tag, ".data"},  out_data, d);
    chk({tag, ".keep"},  {28'h0, out_keep}, {28'h0, k});
    chk({tag, ".last"},  {31'h0, out_last}, {31'h0, l});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; flush = 1'b0;
    out_ready = 1'b1; clear_flags = 1'b0;
    step(); step();
    chk("rst.valid", {31'h0, out_valid}, 32'h0);
    chk("rst.data", out_data, 32'h0);
    chk("rst.keep", {28'h0, out_keep}, 32'h0);
    chk("rst.last", {31'h0, out_last}, 32'h0);
    chk("rst.flags", {29'h0, sat_flag, nan_flag, unf_flag}, 32'h0);
    chk("rst.in_ready", {31'h0, in_ready}, 32'h1);
    rst = 1'b0;

    // 1: full word, one-cycle latency
    send(16'h3F80, 0, 0); send(16'h4000, 0, 0); send(16'hBF80, 0, 0);
    chk("t1.early", {31'h0, out_valid}, 32'h0);
    send(16'h3F00, 0, 0);
    chk_word("t1", 32'h30B84038, 4'hF, 1'b0);
    chk("t1.flags", {29'h0, sat_flag, nan_flag, unf_flag}, 32'h0);
    step();
    chk("t1.drain", {31'h0, out_valid}, 32'h0);

    // 2: in_last partial word, then next word starts at lane 0 (flush with beat)
    send(16'h3F80, 0, 0); send(16'h3F80, 0, 0); send(16'h4000, 1, 0);
    chk_word("t2", 32'h00403838, 4'h7, 1'b1);
    send(16'h4000, 0, 1);
    chk_word("t2.next", 32'h00000040, 4'h1, 1'b0);
    step();

    // 3: stall for 10 cycles, release with a beat in the same cycle
    out_ready = 1'b0;
    send(16'h3F80, 0, 0); send(16'h4000, 0, 0); send(16'hBF80, 0, 0); send(16'h3F00, 0, 0);
    chk_word("t3", 32'h30B84038, 4'hF, 1'b0);
    in_valid = 1'b1; in_data = 16'h4000;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3.stall_ready", {31'h0, in_ready}, 32'h0);
      chk("t3.stall_data", out_data, 32'h30B84038);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("t3.release_ready", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0; in_data = 16'h0;
    chk("t3.handshake", {31'h0, out_valid}, 32'h0);
    flush = 1'b1; step(); flush = 1'b0;
    chk_word("t3.lane0", 32'h00000040, 4'h1, 1'b0);

    // 4: flags
    send(16'h4380, 0, 1);
    chk_word("t4.sat", 32'h00000078, 4'h1, 1'b0);
    chk("t4.sat_flag", {31'h0, sat_flag}, 32'h1);
    send(16'h7FC0, 0, 1);
    chk("t4.nan_lane", out_data, 32'h00000079);
    chk("t4.nan_flag", {31'h0, nan_flag}, 32'h1);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("t4.clear", {30'h0, sat_flag, nan_flag}, 32'h0);
    clear_flags = 1'b1; send(16'h4380, 0, 1); clear_flags = 1'b0;
    chk("t4.set_wins", {31'h0, sat_flag}, 32'h1);
    send(16'h0001, 0, 1);
    chk("t4.unf_lane", out_data, 32'h00000000);
    chk("t4.unf_flag", {31'h0, unf_flag}, 32'h1);
    send(16'h3F98, 0, 1);
    chk("t4.round", out_data, 32'h0000003A);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;

    // 5: flush of a single beat, then an empty flush
    send(16'h4370, 0, 0);
    chk("t5.no_close", {31'h0, out_valid}, 32'h0);
    flush = 1'b1; step(); flush = 1'b0;
    chk_word("t5", 32'h00000077, 4'h1, 1'b0);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    chk("t5.empty_flush", {31'h0, out_valid}, 32'h0);

    // 6: reset mid-word, fresh word, pending flush across a stall
    send(16'h3F80, 0, 0); send(16'h4000, 0, 0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6.rst_valid", {31'h0, out_valid}, 32'h0);
    step();
    chk("t6.rst_nowd", {31'h0, out_valid}, 32'h0);
    send(16'h3F00, 0, 0); send(16'h3F00, 0, 0);
    chk("t6.cnt0", {31'h0, out_valid}, 32'h0);
    send(16'h3F00, 0, 0);
    out_ready = 1'b0;
    send(16'h3F00, 0, 0);
    chk_word("t6.fresh", 32'h30303030, 4'hF, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("t6.held", out_data, 32'h30303030);
    chk("t6.stalled", {31'h0, in_ready}, 32'h0);
    out_ready = 1'b1;
    send(16'h3F80, 0, 0);
    chk_word("t6.pend", 32'h00000038, 4'h1, 1'b0);
    step();
    chk("t6.drain", {31'h0, out_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
